// File: rtl/branch_predictor_btb.sv
// -----------------------------------------------------------------------------
// branch_predictor_btb
//
// Fetch-stage dynamic branch predictor. A direct-mapped branch target buffer
// (valid/tag/target per entry) and a table of saturating counters are looked
// up combinationally with the current fetch PC to produce a same-cycle
// next-PC prediction. Branches resolved in decode train both tables and feed
// two saturating statistics counters. With GSHARE=1 the counter index is the
// BTB index XOR a global history register of recent outcomes.
//
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   fetch_pc            PC being fetched (lookup key)
//   pred_hit            BTB entry valid and tag matches fetch_pc
//   pred_taken          predicted taken (hit and counter MSB set)
//   pred_target         predicted next PC (BTB target or fetch_pc + 2)
//   upd_valid           one-cycle pulse: a branch resolved in decode
//   upd_stall           pipeline stall, blocks the update this cycle
//   upd_pc              PC of the resolved branch
//   upd_taken           actual outcome
//   upd_target          actual taken target
//   upd_pred_taken      prediction made for this branch at fetch
//   upd_pred_target     target predicted at fetch
//   clr_stats           synchronous clear of the statistics counters
//   branch_cnt          resolved branches counted (saturating)
//   mispredict_cnt      mispredictions counted (saturating)
// -----------------------------------------------------------------------------
module branch_predictor_btb #(
    parameter int ADDR_W   = 16,
    parameter int IDX_W    = 4,
    parameter int CTR_W    = 2,
    parameter int CTR_INIT = 1,
    parameter int GSHARE   = 0,
    parameter int STAT_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] fetch_pc,
    output logic              pred_hit,
    output logic              pred_taken,
    output logic [ADDR_W-1:0] pred_target,
    input  logic              upd_valid,
    input  logic              upd_stall,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic              upd_taken,
    input  logic [ADDR_W-1:0] upd_target,
    input  logic              upd_pred_taken,
    input  logic [ADDR_W-1:0] upd_pred_target,
    input  logic              clr_stats,
    output logic [STAT_W-1:0] branch_cnt,
    output logic [STAT_W-1:0] mispredict_cnt
);

    localparam int ENTRIES = 1 << IDX_W;
    localparam int TAG_W   = ADDR_W - IDX_W - 1;

    localparam logic [CTR_W-1:0]  CTR_MAX  = '1;
    localparam logic [CTR_W-1:0]  CTR_RST  = CTR_W'(CTR_INIT);
    localparam logic [STAT_W-1:0] STAT_MAX = '1;

    // Table state
    logic              valid_q [ENTRIES];
    logic              valid_d [ENTRIES];
    logic [TAG_W-1:0]  tag_q   [ENTRIES];
    logic [TAG_W-1:0]  tag_d   [ENTRIES];
    logic [ADDR_W-1:0] tgt_q   [ENTRIES];
    logic [ADDR_W-1:0] tgt_d   [ENTRIES];
    logic [CTR_W-1:0]  ctr_q   [ENTRIES];
    logic [CTR_W-1:0]  ctr_d   [ENTRIES];
    logic [IDX_W-1:0]  ghr_q, ghr_d;

    logic [STAT_W-1:0] branch_cnt_q, branch_cnt_d;
    logic [STAT_W-1:0] mispredict_cnt_q, mispredict_cnt_d;

    // Halfword-aligned instructions: pc[0] never participates in index or tag.
    logic unused_pc_lsb;
    assign unused_pc_lsb = fetch_pc[0] ^ upd_pc[0];

    // Global history mixed into the counter index only in gshare mode.
    logic [IDX_W-1:0] ghr_mix;
    assign ghr_mix = (GSHARE != 0) ? ghr_q : '0;

    // -------------------------------------------------------------------------
    // Lookup: purely combinational from registered state, so an update in the
    // same cycle is not visible until after the edge (no write-through).
    // -------------------------------------------------------------------------
    logic [IDX_W-1:0] f_bidx, f_cidx;
    logic [TAG_W-1:0] f_tag;

    assign f_bidx = fetch_pc[IDX_W:1];
    assign f_tag  = fetch_pc[ADDR_W-1:IDX_W+1];
    assign f_cidx = f_bidx ^ ghr_mix;

    assign pred_hit    = valid_q[f_bidx] && (tag_q[f_bidx] == f_tag);
    assign pred_taken  = pred_hit && ctr_q[f_cidx][CTR_W-1];
    // Sequential path wraps modulo 2^ADDR_W.
    assign pred_target = pred_taken ? tgt_q[f_bidx] : fetch_pc + ADDR_W'(2);

    // -------------------------------------------------------------------------
    // Update: upd_valid is a single-cycle pulse qualified by ~upd_stall; a
    // stalled pulse changes nothing and is re-presented by the pipeline.
    // -------------------------------------------------------------------------
    logic             upd_fire;
    logic             mispredict;
    logic [IDX_W-1:0] u_bidx, u_cidx;
    logic [TAG_W-1:0] u_tag;

    assign upd_fire = upd_valid && !upd_stall;
    assign u_bidx   = upd_pc[IDX_W:1];
    assign u_tag    = upd_pc[ADDR_W-1:IDX_W+1];
    assign u_cidx   = u_bidx ^ ghr_mix;   // pre-edge history

    // Wrong direction, or right direction (taken) but wrong target.
    assign mispredict = (upd_pred_taken != upd_taken) ||
                        (upd_taken && upd_pred_taken && (upd_pred_target != upd_target));

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        tgt_d   = tgt_q;
        ctr_d   = ctr_q;
        ghr_d   = ghr_q;

        if (upd_fire) begin
            if (upd_taken) begin
                if (ctr_q[u_cidx] != CTR_MAX) begin
                    ctr_d[u_cidx] = ctr_q[u_cidx] + CTR_W'(1);
                end
                // Direct-mapped allocate: any alias at this index is replaced.
                valid_d[u_bidx] = 1'b1;
                tag_d[u_bidx]   = u_tag;
                tgt_d[u_bidx]   = upd_target;
            end else begin
                if (ctr_q[u_cidx] != '0) begin
                    ctr_d[u_cidx] = ctr_q[u_cidx] - CTR_W'(1);
                end
            end
            if (GSHARE != 0) begin
                // Shift the newest outcome into the LSB, dropping the oldest.
                ghr_d = IDX_W'({ghr_q, upd_taken});
            end
        end
    end

    // Statistics: clear has priority over a coincident update.
    always_comb begin
        branch_cnt_d     = branch_cnt_q;
        mispredict_cnt_d = mispredict_cnt_q;
        if (clr_stats) begin
            branch_cnt_d     = '0;
            mispredict_cnt_d = '0;
        end else if (upd_fire) begin
            if (branch_cnt_q != STAT_MAX) begin
                branch_cnt_d = branch_cnt_q + STAT_W'(1);
            end
            if (mispredict && (mispredict_cnt_q != STAT_MAX)) begin
                mispredict_cnt_d = mispredict_cnt_q + STAT_W'(1);
            end
        end
    end

    // State with reset: valid bits, counters, history, statistics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= CTR_RST;
            end
            ghr_q            <= '0;
            branch_cnt_q     <= '0;
            mispredict_cnt_q <= '0;
        end else begin
            valid_q          <= valid_d;
            ctr_q            <= ctr_d;
            ghr_q            <= ghr_d;
            branch_cnt_q     <= branch_cnt_d;
            mispredict_cnt_q <= mispredict_cnt_d;
        end
    end

    // Tag and target arrays are qualified by valid, so they need no reset.
    always_ff @(posedge clk) begin
        tag_q <= tag_d;
        tgt_q <= tgt_d;
    end

    assign branch_cnt     = branch_cnt_q;
    assign mispredict_cnt = mispredict_cnt_q;

endmodule

// File: tb/tb_branch_predictor_btb.sv
// -----------------------------------------------------------------------------
// tb_branch_predictor_btb
//
// Drives a bimodal instance (dut0) and a gshare instance (dut1) with the same
// stimulus. Expected lookups {hit, taken, target} and statistics
// {branch_cnt, mispredict_cnt} are pushed into queues and popped for compare.
// -----------------------------------------------------------------------------
module tb_branch_predictor_btb;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] fetch_pc = '0;
    logic        upd_valid = 1'b0;
    logic        upd_stall = 1'b0;
    logic [15:0] upd_pc = '0;
    logic        upd_taken = 1'b0;
    logic [15:0] upd_target = '0;
    logic        upd_pred_taken = 1'b0;
    logic [15:0] upd_pred_target = '0;
    logic        clr_stats = 1'b0;

    logic        pred_hit0, pred_taken0, pred_hit1, pred_taken1;
    logic [15:0] pred_target0, pred_target1;
    logic [15:0] bc0, mc0, bc1, mc1;

    int checks = 0;
    int failures = 0;

    logic [17:0] exp_pred_q [$];
    logic [31:0] exp_stat_q [$];
    logic [17:0] exp_pred, got_pred;
    logic [31:0] exp_stat, got_stat;
    logic [15:0] exp_branch = '0;
    logic [15:0] exp_mis = '0;

    branch_predictor_btb dut0 (
        .clk(clk), .rst_n(rst_n), .fetch_pc(fetch_pc),
        .pred_hit(pred_hit0), .pred_taken(pred_taken0), .pred_target(pred_target0),
        .upd_valid(upd_valid), .upd_stall(upd_stall), .upd_pc(upd_pc),
        .upd_taken(upd_taken), .upd_target(upd_target),
        .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
        .clr_stats(clr_stats), .branch_cnt(bc0), .mispredict_cnt(mc0)
    );

    branch_predictor_btb #(.GSHARE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .fetch_pc(fetch_pc),
        .pred_hit(pred_hit1), .pred_taken(pred_taken1), .pred_target(pred_target1),
        .upd_valid(upd_valid), .upd_stall(upd_stall), .upd_pc(upd_pc),
        .upd_taken(upd_taken), .upd_target(upd_target),
        .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
        .clr_stats(clr_stats), .branch_cnt(bc1), .mispredict_cnt(mc1)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        exp_branch = '0;
        exp_mis = '0;
    endtask

    // One unstalled update pulse; tracks the expected statistics.
    task automatic drive_update(input logic [15:0] pc, input logic t, input logic [15:0] tg,
                                input logic pt, input logic [15:0] ptg);
        logic mis;
        @(negedge clk);
        upd_valid = 1'b1;
        upd_pc = pc;
        upd_taken = t;
        upd_target = tg;
        upd_pred_taken = pt;
        upd_pred_target = ptg;
        @(negedge clk);
        upd_valid = 1'b0;
        mis = (pt != t) || (t && pt && (ptg != tg));
        if (exp_branch != 16'hFFFF) exp_branch = exp_branch + 16'd1;
        if (mis && exp_mis != 16'hFFFF) exp_mis = exp_mis + 16'd1;
    endtask

    task automatic drive_fetch(input logic [15:0] pc);
        @(negedge clk);
        fetch_pc = pc;
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        apply_reset();
        exp_pred_q.push_back({1'b0, 1'b0, 16'h0012});
        drive_fetch(16'h0010);
        got_pred = {pred_hit0, pred_taken0, pred_target0};
        exp_pred = exp_pred_q.pop_front();
        checks++;
        if (got_pred !== exp_pred) begin failures++; $display("FAIL reset_lookup got=%h exp=%h", got_pred, exp_pred); end

        exp_stat_q.push_back(32'h0);
        got_stat = {bc0, mc0};
        exp_stat = exp_stat_q.pop_front();
        checks++;
        if (got_stat !== exp_stat) begin failures++; $display("FAIL reset_stats got=%h exp=%h", got_stat, exp_stat); end

        exp_pred_q.push_back({1'b0, 1'b0, 16'h0000});
        drive_fetch(16'hFFFE);
        got_pred = {pred_hit0, pred_taken0, pred_target0};
        exp_pred = exp_pred_q.pop_front();
        checks++;
        if (got_pred !== exp_pred) begin failures++; $display("FAIL wrap_target got=%h exp=%h", got_pred, exp_pred); end
    endtask

    task automatic test_single_update();
        drive_update(16'h0010, 1'b1, 16'h0040, 1'b0, 16'h0000);
        exp_pred_q.push_back({1'b1, 1'b1, 16'h0040});
        exp_stat_q.push_back({16'd1, 16'd1});
        drive_fetch(16'h0010);
        got_pred = {pred_hit0, pred_taken0, pred_target0};
        exp_pred = exp_pred_q.pop_front();
        checks++;
        if (got_pred !== exp_pred) begin failures++; $display("FAIL single_lookup got=%h exp=%h", got_pred, exp_pred); end
        got_stat = {bc0, mc0};
        exp_stat = exp_stat_q.pop_front();
        checks++;
        if (got_stat !== exp_stat) begin failures++; $display("FAIL single_stats got=%h exp=%h", got_stat, exp_stat); end
    endtask

    task automatic test_hysteresis();
        for (int i = 0; i < 4; i++) drive_update(16'h0010, 1'b1, 16'h0040, 1'b1, 16'h0040);
        drive_update(16'h0010, 1'b0, 16'h0000, 1'b1, 16'h0040);
        exp_pred_q.push_back({1'b1, 1'b1, 16'h0040});
        drive_fetch(16'h0010);
        got_pred = {pred_hit0, pred_taken0, pred_target0};
        exp_pred = exp_pred_q.pop_front();
        checks++;
        if (got_pred !== exp_pred) begin failures++; $display("FAIL hyst_one_nt got=%h exp=%h", got_pred, exp_pred); end

        drive_update(16'h0010, 1'b0, 16'h0000, 1'b1, 16'h0040);
        exp_pred_q.push_back({1'b1, 1'b0, 16'h0012});
        drive_fetch(16'h0010);
        got_pred = {pred_hit0, pred_taken0, pred_target0};
        exp_pred = exp_pred_q.pop_front();
        checks++;
        if (got_pred !== exp_pred) begin failures++; $display("FAIL hyst_two_nt got=%h exp=%h", got_pred, exp_pred); end

        // Correct direction, wrong target still counts as a mispredict.
        drive_update(16'h0010, 1'b1, 16'h0040, 1'b1, 16'h0044);
        exp_stat_q.push_back({16'd8, 16'd4});
        got_stat = {bc0, mc0};
        exp_stat = exp_stat_q.pop_front();
        checks++;
        if (got_stat !== exp_stat) begin failures++; $display("FAIL hyst_stats got=%h exp=%h", got_stat, exp_stat); end
    endtask

    task automatic test_alias();
        drive_update(16'h0030, 1'b1, 16'h0100, 1'b0, 16'h0000);
        exp_pred_q.push_back({1'b0, 1'b0, 16'h0012});
        exp_pred_q.push_back({1'b1, 1'b1, 16'h0100});
        drive_fetch(16'h0010);
        got_pred = {pred_hit0, pred_taken0, pred_target0};
        exp_pred = exp_pred_q.pop_front();
        checks++;
        if (got_pred !== exp_pred) begin failures++; $display("FAIL alias_evicted got=%h exp=%h", got_pred, exp_pred); end
        drive_fetch(16'h0030);
        got_pred = {pred_hit0, pred_taken0, pred_target0};
        exp_pred = exp_pred_q.pop_front();
        checks++;
        if (got_pred !== exp_pred) begin failures++; $display("FAIL alias_new got=%h exp=%h", got_pred, exp_pred); end

        // A not-taken branch never allocates.
        drive_update(16'h0020, 1'b0, 16'h0000, 1'b0, 16'h0000);
        exp_pred_q.push_back({1'b0, 1'b0, 16'h0022});
        drive_fetch(16'h0020);
        got_pred = {pred_hit0, pred_taken0, pred_target0};
        exp_pred = exp_pred_q.pop_front();
        checks++;
        if (got_pred !== exp_pred) begin failures++; $display("FAIL nt_no_alloc got=%h exp=%h", got_pred, exp_pred); end
    endtask

    task automatic test_stall();
        @(negedge clk);
        upd_valid = 1'b1;
        upd_stall = 1'b1;
        upd_pc = 16'h0050;
        upd_taken = 1'b1;
        upd_target = 16'h0200;
        upd_pred_taken = 1'b0;
        @(negedge clk);
        upd_valid = 1'b0;
        upd_stall = 1'b0;
        exp_pred_q.push_back({1'b0, 1'b0, 16'h0052});
        exp_stat_q.push_back({exp_branch, exp_mis});
        drive_fetch(16'h0050);
        got_pred = {pred_hit0, pred_taken0, pred_target0};
        exp_pred = exp_pred_q.pop_front();
        checks++;
        if (got_pred !== exp_pred) begin failures++; $display("FAIL stall_btb got=%h exp=%h", got_pred, exp_pred); end
        got_stat = {bc0, mc0};
        exp_stat = exp_stat_q.pop_front();
        checks++;
        if (got_stat !== exp_stat) begin failures++; $display("FAIL stall_stats got=%h exp=%h", got_stat, exp_stat); end
    endtask

    task automatic test_same_cycle();
        @(negedge clk);
        fetch_pc = 16'h0060;
        upd_valid = 1'b1;
        upd_pc = 16'h0060;
        upd_taken = 1'b1;
        upd_target = 16'h0300;
        upd_pred_taken = 1'b0;
        exp_pred_q.push_back({1'b0, 1'b0, 16'h0062});
        #1;
        got_pred = {pred_hit0, pred_taken0, pred_target0};
        exp_pred = exp_pred_q.pop_front();
        checks++;
        if (got_pred !== exp_pred) begin failures++; $display("FAIL same_cycle_pre got=%h exp=%h", got_pred, exp_pred); end
        @(negedge clk);
        upd_valid = 1'b0;
        exp_branch = exp_branch + 16'd1;
        exp_mis = exp_mis + 16'd1;
        // Counter 0 was driven to 0 by the 0x0020 not-taken, now back to 1.
        exp_pred_q.push_back({1'b1, 1'b0, 16'h0062});
        #1;
        got_pred = {pred_hit0, pred_taken0, pred_target0};
        exp_pred = exp_pred_q.pop_front();
        checks++;
        if (got_pred !== exp_pred) begin failures++; $display("FAIL same_cycle_post got=%h exp=%h", got_pred, exp_pred); end
    endtask

    task automatic test_clr_with_update();
        @(negedge clk);
        clr_stats = 1'b1;
        upd_valid = 1'b1;
        upd_pc = 16'h0004;
        upd_taken = 1'b1;
        upd_target = 16'h0400;
        upd_pred_taken = 1'b0;
        @(negedge clk);
        clr_stats = 1'b0;
        upd_valid = 1'b0;
        exp_branch = '0;
        exp_mis = '0;
        exp_stat_q.push_back(32'h0);
        exp_pred_q.push_back({1'b1, 1'b1, 16'h0400});
        got_stat = {bc0, mc0};
        exp_stat = exp_stat_q.pop_front();
        checks++;
        if (got_stat !== exp_stat) begin failures++; $display("FAIL clr_stats got=%h exp=%h", got_stat, exp_stat); end
        drive_fetch(16'h0004);
        got_pred = {pred_hit0, pred_taken0, pred_target0};
        exp_pred = exp_pred_q.pop_front();
        checks++;
        if (got_pred !== exp_pred) begin failures++; $display("FAIL clr_table_upd got=%h exp=%h", got_pred, exp_pred); end

        drive_update(16'h0004, 1'b1, 16'h0400, 1'b1, 16'h0400);
        exp_stat_q.push_back({16'd1, 16'd0});
        got_stat = {bc0, mc0};
        exp_stat = exp_stat_q.pop_front();
        checks++;
        if (got_stat !== exp_stat) begin failures++; $display("FAIL clr_resume got=%h exp=%h", got_stat, exp_stat); end
    endtask

    task automatic test_gshare();
        logic [15:0] sh_pc [4];
        logic        sh_t  [4];
        sh_pc = '{16'h0006, 16'h0006, 16'h0006, 16'h0006};
        sh_t  = '{1'b0, 1'b0, 1'b1, 1'b1};

        apply_reset();
        drive_update(16'h0010, 1'b1, 16'h0040, 1'b0, 16'h0000);  // cidx 8, ghr=0001
        drive_update(16'h0002, 1'b1, 16'h0500, 1'b0, 16'h0000);  // cidx 0, ghr=0011
        // ghr=0011: gshare reads untrained ctr[11]; bimodal reads trained ctr[8].
        exp_pred_q.push_back({1'b1, 1'b0, 16'h0012});
        exp_pred_q.push_back({1'b1, 1'b1, 16'h0040});
        drive_fetch(16'h0010);
        got_pred = {pred_hit1, pred_taken1, pred_target1};
        exp_pred = exp_pred_q.pop_front();
        checks++;
        if (got_pred !== exp_pred) begin failures++; $display("FAIL gshare_idx11 got=%h exp=%h", got_pred, exp_pred); end
        got_pred = {pred_hit0, pred_taken0, pred_target0};
        exp_pred = exp_pred_q.pop_front();
        checks++;
        if (got_pred !== exp_pred) begin failures++; $display("FAIL bimodal_idx8 got=%h exp=%h", got_pred, exp_pred); end

        drive_update(16'h0010, 1'b1, 16'h0040, 1'b0, 16'h0000);  // trains ctr[11], ghr=0111
        exp_pred_q.push_back({1'b1, 1'b0, 16'h0012});            // now reads ctr[15]
        drive_fetch(16'h0010);
        got_pred = {pred_hit1, pred_taken1, pred_target1};
        exp_pred = exp_pred_q.pop_front();
        checks++;
        if (got_pred !== exp_pred) begin failures++; $display("FAIL gshare_idx15 got=%h exp=%h", got_pred, exp_pred); end

        // Outcomes 0,0,1,1 bring ghr back to 0011 without touching ctr[11].
        for (int i = 0; i < 4; i++) drive_update(sh_pc[i], sh_t[i], 16'h0700, 1'b0, 16'h0000);
        exp_pred_q.push_back({1'b1, 1'b1, 16'h0040});
        drive_fetch(16'h0010);
        got_pred = {pred_hit1, pred_taken1, pred_target1};
        exp_pred = exp_pred_q.pop_front();
        checks++;
        if (got_pred !== exp_pred) begin failures++; $display("FAIL gshare_trained got=%h exp=%h", got_pred, exp_pred); end

        // Asynchronous reset between edges.
        rst_n = 1'b0;
        #1;
        exp_pred_q.push_back({1'b0, 1'b0, 16'h0012});
        exp_pred_q.push_back({1'b0, 1'b0, 16'h0012});
        exp_stat_q.push_back(32'h0);
        got_pred = {pred_hit1, pred_taken1, pred_target1};
        exp_pred = exp_pred_q.pop_front();
        checks++;
        if (got_pred !== exp_pred) begin failures++; $display("FAIL async_rst_g got=%h exp=%h", got_pred, exp_pred); end
        got_pred = {pred_hit0, pred_taken0, pred_target0};
        exp_pred = exp_pred_q.pop_front();
        checks++;
        if (got_pred !== exp_pred) begin failures++; $display("FAIL async_rst_b got=%h exp=%h", got_pred, exp_pred); end
        got_stat = {bc1, mc1};
        exp_stat = exp_stat_q.pop_front();
        checks++;
        if (got_stat !== exp_stat) begin failures++; $display("FAIL async_rst_stats got=%h exp=%h", got_stat, exp_stat); end
        rst_n = 1'b1;
        exp_branch = '0;
        exp_mis = '0;
    endtask

    task automatic test_stats_saturation();
        apply_reset();
        @(negedge clk);
        upd_valid = 1'b1;
        upd_pc = 16'h0008;
        upd_taken = 1'b0;
        upd_target = '0;
        upd_pred_taken = 1'b0;
        upd_pred_target = '0;
        repeat (65535) @(negedge clk);
        upd_valid = 1'b0;
        exp_branch = 16'hFFFF;
        exp_mis = 16'h0000;
        exp_stat_q.push_back({16'hFFFF, 16'h0000});
        got_stat = {bc0, mc0};
        exp_stat = exp_stat_q.pop_front();
        checks++;
        if (got_stat !== exp_stat) begin failures++; $display("FAIL sat_reach got=%h exp=%h", got_stat, exp_stat); end

        drive_update(16'h0008, 1'b0, 16'h0000, 1'b1, 16'h0000);
        exp_stat_q.push_back({16'hFFFF, 16'h0001});
        got_stat = {bc0, mc0};
        exp_stat = exp_stat_q.pop_front();
        checks++;
        if (got_stat !== exp_stat) begin failures++; $display("FAIL sat_hold got=%h exp=%h", got_stat, exp_stat); end
    endtask

    // ---------------- main sequence + report ----------------
    initial begin
        test_reset();
        test_single_update();
        test_hysteresis();
        test_alias();
        test_stall();
        test_same_cycle();
        test_clr_with_update();
        test_gshare();
        test_stats_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
